// File: rtl/data_memory.sv
// Backing line memory for the write-back data cache: 512 x 256-bit lines,
// one whole-line read or write per request, completed after a fixed latency.
module data_memory #(
    parameter int MEM_LATENCY = 10,  // must be >= 2
    parameter int LINE_BITS   = 256,
    parameter int DEPTH       = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // FSM state and latency counter grouped so checkers can bind to one signal.
    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] cnt;
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 last_cycle;
    logic                 mem_we;
    logic                 unused_addr;

    logic [LINE_BITS-1:0] memory [DEPTH];

    // Byte offset and high address bits never select a line.
    assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    // Handshake: enable_i is a request strobe taken only in IDLE (the block is
    // "ready" exactly when IDLE); the request is latched at that edge, all
    // inputs are ignored while BUSY, and ack_o pulses for one cycle when done.
    always_comb begin
        last_cycle = (fsm_q.state == BUSY) && (fsm_q.cnt == CNT_LAST);
        fsm_d      = fsm_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        mem_we     = 1'b0;
        case (fsm_q.state)
            IDLE: begin
                if (enable_i) begin
                    fsm_d.state = BUSY;
                    fsm_d.cnt   = '0;
                    idx_d       = addr_i[IDX_W+4:5];
                    wdata_d     = data_i;
                    write_d     = write_i;
                end
            end
            BUSY: begin
                if (last_cycle) begin
                    fsm_d.state = IDLE;
                    fsm_d.cnt   = '0;
                    mem_we      = write_q;
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 1'b1;
                end
            end
            default: begin
                fsm_d.state = IDLE;
                fsm_d.cnt   = '0;
            end
        endcase
    end

    always_comb begin
        ack_o  = last_cycle;
        data_o = last_cycle ? memory[idx_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q.state <= IDLE;
            fsm_q.cnt   <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // The array is never reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            memory[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_data_memory;

    localparam int L = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         en;
    logic         wr;
    logic         ack;
    logic [255:0] dout;

    data_memory #(.MEM_LATENCY(L), .LINE_BITS(256), .DEPTH(512)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (din),
        .enable_i (en),
        .write_i  (wr),
        .ack_o    (ack),
        .data_o   (dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a request accepted at edge number acc is acknowledged
    // in the cycle after edge acc+L-1 and retires at edge acc+L.
    logic [255:0] ref_mem [512];
    int           cycle = 0;
    bit           pend = 0;
    int           acc = 0;
    logic [8:0]   p_idx = '0;
    logic [255:0] p_dat = '0;
    bit           p_wr = 0;

    localparam logic [255:0] PAT0 =
        256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] PAT1 =
        256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [255:0] PATW = {16{16'hECFA}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit exp_ack;
        @(posedge clk);
        cycle++;
        if (rst) begin
            pend = 0;
        end else if (pend && cycle == acc + L) begin
            if (p_wr) ref_mem[p_idx] = p_dat;
            pend = 0;
        end else if (!pend && en) begin
            pend  = 1;
            acc   = cycle;
            p_idx = addr[13:5];
            p_dat = din;
            p_wr  = wr;
        end
        #1;
        exp_ack = pend && (cycle == acc + L - 1);
        chk("ack_o", {255'd0, ack}, {255'd0, exp_ack});
        chk("data_o", dout, exp_ack ? ref_mem[p_idx] : 256'd0);
    endtask

    task automatic req_start(input logic w, input logic [31:0] a, input logic [255:0] d);
        en   = 1'b1;
        wr   = w;
        addr = a;
        din  = d;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (ack !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 256'(n), 256'(L - 1));
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d, input string tag);
        req_start(w, a, d);
        wait_ack(tag);
        tick();
    endtask

    initial begin
        int           ack_cycles[$];
        logic [255:0] old_line;
        logic [255:0] rnd;

        rst  = 1'b1;
        en   = 1'b0;
        wr   = 1'b0;
        addr = '0;
        din  = '0;
        for (int i = 0; i < 512; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            dut.memory[i] = rnd;
            ref_mem[i]    = rnd;
        end
        dut.memory[0] = PAT0;
        ref_mem[0]    = PAT0;
        dut.memory[1] = PAT1;
        ref_mem[1]    = PAT1;

        // Reset state
        repeat (3) tick();
        chk("reset state", {255'd0, dut.fsm_q.state}, 256'd0);
        chk("reset cnt", 256'(dut.fsm_q.cnt), 256'd0);
        rst = 1'b0;
        tick();

        // Read line 0
        req_start(1'b0, 32'h0000_0000, '0);
        wait_ack("read0");
        chk("read0 data", dout, PAT0);
        tick();
        chk("read0 data after", dout, 256'd0);

        // Write line 18, then read it through a different offset
        old_line = ref_mem[18];
        req_start(1'b1, 32'h0000_0240, PATW);
        repeat (L - 1) tick();
        chk("write18 ack cycle", {255'd0, ack}, {255'd0, 1'b1});
        chk("write18 before commit", dut.memory[18], old_line);
        tick();
        chk("write18 after commit", dut.memory[18], PATW);
        req_start(1'b0, 32'h0000_0250, '0);
        wait_ack("read18");
        chk("read18 data", dout, PATW);
        tick();

        // Single-cycle enable, inputs scrambled while BUSY
        rnd = {8{$urandom}};
        req_start(1'b1, 32'h0000_1A60, rnd);
        addr = $urandom;
        din  = ~rnd;
        wr   = 1'b0;
        wait_ack("pulse");
        tick();
        chk("pulse line", dut.memory[9'h0D3], rnd);
        req(1'b0, 32'h0000_1A7F, '0, "pulse readback");

        // Aliasing on high and offset bits
        req_start(1'b0, 32'h0000_4020, '0);
        wait_ack("alias");
        chk("alias data", dout, PAT1);
        tick();

        // Back-to-back with enable held high
        en   = 1'b1;
        wr   = 1'b0;
        addr = $urandom;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack) ack_cycles.push_back(cycle);
        end
        en = 1'b0;
        chk("b2b ack count", 256'(ack_cycles.size() >= 3), 256'd1);
        for (int i = 1; i < ack_cycles.size(); i++) begin
            chk("b2b ack spacing", 256'(ack_cycles[i] - ack_cycles[i-1]), 256'd11);
        end
        repeat (12) tick();

        // Reset in the middle of a write
        old_line = ref_mem[77];
        req_start(1'b1, 32'(77 << 5), ~old_line);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("rst write discarded", dut.memory[77], old_line);
        chk("rst state idle", {255'd0, dut.fsm_q.state}, 256'd0);
        req(1'b0, 32'(77 << 5), '0, "after reset");

        // Random traffic
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req(1'($urandom_range(0, 1)), $urandom, rnd, "random");
        end

        for (int i = 0; i < 512; i++) begin
            chk("final array", dut.memory[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
